// File: rtl/wb_arbiter_pkg.sv
// Shared widths and the write-request record used by the writeback arbiter
// and its result FIFO.
package wb_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO for long-latency results. The head is read
// combinationally so the arbiter can write it in the cycle it is selected.
module wb_result_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_arbiter_pkg::wb_req_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  entry_t                   push_data_i,
  input  logic                     pop_i,
  output entry_t                   head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  entry_t               mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [AW:0]          count_q;
  logic                 do_push;
  logic                 do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Storage is left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writebacks win, buffered
// long-latency results fill idle slots, with a pending-rd scoreboard and starvation stall.
module wb_arbiter #(
  parameter int XLEN         = wb_arbiter_pkg::XLEN,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wb_valid,
  input  logic [wb_arbiter_pkg::REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]                     wb_data,
  input  logic                                lu_issue,
  input  logic [wb_arbiter_pkg::REG_ADDR_W-1:0] lu_issue_rd,
  input  logic                                lu_valid,
  output logic                                lu_ready,
  input  logic [wb_arbiter_pkg::REG_ADDR_W-1:0] lu_rd,
  input  logic [XLEN-1:0]                     lu_data,
  output logic                                rf_we,
  output logic [wb_arbiter_pkg::REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]                     rf_wd,
  output logic [wb_arbiter_pkg::NUM_REGS-1:0] pending_mask,
  output logic                                stall_req
);

  import wb_arbiter_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_req_t               push_req;
  wb_req_t               head;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  slot_busy;
  logic                  push;
  logic                  pop;

  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  stall_q, stall_d;

  assign slot_busy     = wb_valid && (wb_rd != '0);
  assign lu_ready      = (fifo_count != CW'(DEPTH));
  // rd=0 results complete the handshake but are silently dropped.
  assign push          = lu_valid && !fifo_full && (lu_rd != '0);
  assign pop           = !slot_busy && !fifo_empty;
  assign push_req.rd   = lu_rd;
  assign push_req.data = lu_data;

  wb_result_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (wb_req_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_req),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    rf_we = 1'b0;
    rf_rd = '0;
    rf_wd = '0;
    if (slot_busy) begin
      rf_we = rst_n;
      rf_rd = wb_rd;
      rf_wd = wb_data;
    end else if (!fifo_empty) begin
      rf_we = rst_n;
      rf_rd = head.rd;
      rf_wd = head.data;
    end
  end

  // A new issue to the same rd as the retiring head must keep the bit set.
  always_comb begin
    pending_d = pending_q;
    if (pop) begin
      pending_d[head.rd] = 1'b0;
    end
    if (lu_issue && (lu_issue_rd != '0)) begin
      pending_d[lu_issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    starve_d = starve_q;
    stall_d  = stall_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
    if (pop) begin
      stall_d = 1'b0;
    end else if (!fifo_empty && (starve_q >= SW'(STARVE_LIMIT - 1))) begin
      stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
    end
  end

  assign pending_mask = pending_q;
  assign stall_req    = stall_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized checks of wb_arbiter against a queue-based model
// of the write-port, scoreboard and starvation rules.
module tb_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              lu_issue;
  logic [4:0]        lu_issue_rd;
  logic              lu_valid;
  logic              lu_ready;
  logic [4:0]        lu_rd;
  logic [XLEN-1:0]   lu_data;
  logic              rf_we;
  logic [4:0]        rf_rd;
  logic [XLEN-1:0]   rf_wd;
  logic [31:0]       pending_mask;
  logic              stall_req;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .lu_issue     (lu_issue),
    .lu_issue_rd  (lu_issue_rd),
    .lu_valid     (lu_valid),
    .lu_ready     (lu_ready),
    .lu_rd        (lu_rd),
    .lu_data      (lu_data),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_wd        (rf_wd),
    .pending_mask (pending_mask),
    .stall_req    (stall_req)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a plain queue of results, a boolean per register, and the
  // length of the current run of cycles in which the head waited without writing.
  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t mq[$];
  bit   mpend[32];
  int   mrun;

  function automatic logic [31:0] model_pending();
    logic [31:0] v;
    v = '0;
    for (int i = 1; i < 32; i++) v[i] = mpend[i];
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
    mrun = 0;
  endtask

  // Apply inputs on the falling edge, then compare every output to the model.
  task automatic cyc_begin(input logic wv, input logic [4:0] wrd, input logic [XLEN-1:0] wd,
                           input logic iv, input logic [4:0] ird,
                           input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld);
    logic            e_we;
    logic [4:0]      e_rd;
    logic [XLEN-1:0] e_wd;
    @(negedge clk);
    wb_valid = wv; wb_rd = wrd; wb_data = wd;
    lu_issue = iv; lu_issue_rd = ird;
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
    #1;
    e_we = 1'b0; e_rd = '0; e_wd = '0;
    if (wv && wrd != 0) begin
      e_we = 1'b1; e_rd = wrd; e_wd = wd;
      check("proto_pending_rd", pending_mask[wrd], 1'b0);
    end else if (mq.size() > 0) begin
      e_we = 1'b1; e_rd = mq[0].rd; e_wd = mq[0].data;
    end
    check("rf_we", rf_we, e_we);
    check("rf_rd", rf_rd, e_rd);
    check("rf_wd", rf_wd, e_wd);
    check("lu_ready", lu_ready, mq.size() < DEPTH);
    check("pending_mask", pending_mask, model_pending());
    check("stall_req", stall_req, mrun >= LIMIT);
  endtask

  task automatic cyc_end();
    bit   busy, nonempty, pop, ready;
    ent_t h, n;
    @(posedge clk);
    cyc++;
    busy     = wb_valid && wb_rd != 0;
    nonempty = mq.size() > 0;
    pop      = !busy && nonempty;
    ready    = mq.size() < DEPTH;
    if (busy) $display("[%0d] rf write x%0d <= %08h (pipeline)", cyc, wb_rd, wb_data);
    if (pop) begin
      h = mq.pop_front();
      mpend[h.rd] = 1'b0;
      $display("[%0d] rf write x%0d <= %08h (long-latency)", cyc, h.rd, h.data);
    end
    if (lu_valid && ready && lu_rd != 0) begin
      n.rd = lu_rd; n.data = lu_data;
      mq.push_back(n);
    end
    if (lu_issue && lu_issue_rd != 0) mpend[lu_issue_rd] = 1'b1;
    if (nonempty && !pop) mrun++;
    else mrun = 0;
  endtask

  task automatic idle();
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 0);
    cyc_end();
  endtask

  logic [4:0] outq[$];

  initial begin
    model_reset();
    rst_n = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1;
    lu_issue = 0; lu_issue_rd = 0; lu_valid = 0; lu_rd = 0; lu_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we_forced", rf_we, 1'b0);
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    rst_n = 1'b1;

    // Reset release
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 0);
    check("rel_we", rf_we, 1'b0);
    check("rel_ready", lu_ready, 1'b1);
    check("rel_pend", pending_mask, 32'h0);
    check("rel_stall", stall_req, 1'b0);
    cyc_end();

    // Pipeline-only write
    cyc_begin(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    check("pipe_we", rf_we, 1'b1);
    check("pipe_rd", rf_rd, 5'd5);
    check("pipe_wd", rf_wd, 32'hDEADBEEF);
    cyc_end();
    cyc_begin(1, 0, 32'h55, 0, 0, 0, 0, 0);
    check("pipe_x0_we", rf_we, 1'b0);
    cyc_end();

    // Issue and complete in an idle slot
    cyc_begin(0, 0, 0, 1, 7, 0, 0, 0); cyc_end();
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 0);
    check("iss_pend", pending_mask, 32'h80);
    cyc_end();
    cyc_begin(0, 0, 0, 0, 0, 1, 7, 32'h1234);
    check("nobypass_we", rf_we, 1'b0);
    cyc_end();
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 0);
    check("lu_we", rf_we, 1'b1);
    check("lu_rd", rf_rd, 5'd7);
    check("lu_wd", rf_wd, 32'h1234);
    cyc_end();
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 0);
    check("lu_pend_clr", pending_mask, 32'h0);
    cyc_end();

    // Full FIFO, then drain in order
    cyc_begin(0, 0, 0, 1, 3, 0, 0, 0); cyc_end();
    cyc_begin(0, 0, 0, 1, 4, 0, 0, 0); cyc_end();
    cyc_begin(1, 10, 32'hA, 0, 0, 1, 3, 32'h33); cyc_end();
    cyc_begin(1, 10, 32'hB, 0, 0, 1, 4, 32'h44); cyc_end();
    cyc_begin(1, 10, 32'hC, 0, 0, 0, 0, 0);
    check("full_ready", lu_ready, 1'b0);
    cyc_end();
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 0);
    check("drain1_rd", rf_rd, 5'd3);
    check("drain1_ready", lu_ready, 1'b0);
    cyc_end();
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 0);
    check("drain2_rd", rf_rd, 5'd4);
    check("drain2_ready", lu_ready, 1'b1);
    cyc_end();
    idle();

    // Starvation
    cyc_begin(0, 0, 0, 1, 9, 0, 0, 0); cyc_end();
    cyc_begin(1, 11, 32'h11, 0, 0, 1, 9, 32'h99); cyc_end();
    for (int k = 0; k < LIMIT; k++) begin
      cyc_begin(1, 11, 32'h11 + k, 0, 0, 0, 0, 0);
      check("starve_low", stall_req, 1'b0);
      cyc_end();
    end
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 0);
    check("starve_high", stall_req, 1'b1);
    check("starve_rd", rf_rd, 5'd9);
    cyc_end();
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 0);
    check("starve_fall", stall_req, 1'b0);
    cyc_end();

    // Same-cycle set and clear of one scoreboard bit; set must win
    cyc_begin(0, 0, 0, 1, 2, 0, 0, 0); cyc_end();
    cyc_begin(0, 0, 0, 0, 0, 1, 2, 32'h22); cyc_end();
    cyc_begin(0, 0, 0, 1, 2, 0, 0, 0);
    check("same_pop_rd", rf_rd, 5'd2);
    cyc_end();
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 0);
    check("same_set_wins", pending_mask, 32'h4);
    cyc_end();
    cyc_begin(0, 0, 0, 0, 0, 1, 2, 32'h222); cyc_end();
    idle();

    // rd=0 result: accepted, dropped
    cyc_begin(0, 0, 0, 0, 0, 1, 0, 32'hBAD);
    check("x0_ready", lu_ready, 1'b1);
    cyc_end();
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 0);
    check("x0_nowrite", rf_we, 1'b0);
    check("x0_ready_after", lu_ready, 1'b1);
    cyc_end();

    // Reset in the middle of traffic
    cyc_begin(0, 0, 0, 1, 12, 0, 0, 0); cyc_end();
    cyc_begin(1, 13, 32'h13, 0, 0, 1, 12, 32'hC); cyc_end();
    @(negedge clk);
    rst_n = 1'b0; wb_valid = 1'b1; wb_rd = 5'd6; lu_valid = 0; lu_issue = 0;
    #1;
    check("midrst_we", rf_we, 1'b0);
    check("midrst_pend", pending_mask, 32'h0);
    check("midrst_ready", lu_ready, 1'b1);
    check("midrst_stall", stall_req, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; wb_valid = 0; wb_rd = 0;
    model_reset();
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 0);
    check("midrst_discard", rf_we, 1'b0);
    cyc_end();

    // Randomized traffic obeying the decode/pipeline protocol
    for (int t = 0; t < 600; t++) begin
      logic            wv, iv, lv;
      logic [4:0]      wrd, ird, lrd;
      logic [XLEN-1:0] wd, ld;
      wd = $urandom; ld = $urandom;
      wv = (mrun < LIMIT) && ($urandom_range(0, 3) != 0);
      wrd = 5'($urandom_range(0, 31));
      if (mpend[wrd]) wrd = 0;
      ird = 5'($urandom_range(1, 31));
      iv = ($urandom_range(0, 3) == 0) && !mpend[ird];
      lv = 0; lrd = 0;
      if (outq.size() > 0) begin
        lv = $urandom_range(0, 1) != 0;
        lrd = outq[0];
      end else if ($urandom_range(0, 7) == 0) begin
        lv = 1'b1;
      end
      if (lv && lrd != 0 && mq.size() < DEPTH) void'(outq.pop_front());
      if (iv) outq.push_back(ird);
      cyc_begin(wv, wrd, wd, iv, ird, lv, lrd, ld);
      cyc_end();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
